// File: rtl/alu_dispatch.sv
// ---------------------------------------------------------------------------
// alu_dispatch
//
// Single-entry registered pipeline stage that takes one decoded-stage RV32I
// instruction (plus its pc and register-file read data) and turns it into a
// registered ALU operation. Only OP, OP-IMM, LUI and AUIPC are executed here.
// Any other encoding still moves through the stage with the normal
// handshake, but it comes out with illegal=1 and zeroed ALU controls.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   flush      in   1   drop the held instruction and refuse a new one
//   in_valid   in   1   upstream presents an instruction
//   in_ready   out  1   stage accepts an instruction this cycle (combinational)
//   inst       in   32  RV32I instruction word
//   pc         in   32  instruction address
//   rs1_data   in   32  register-file read data for rs1
//   rs2_data   in   32  register-file read data for rs2
//   out_valid  out  1   a registered ALU operation is available
//   out_ready  in   1   downstream consumes the operation
//   alu_a      out  32  ALU operand a
//   alu_b      out  32  ALU operand b
//   alu_crl    out  4   ALU operation select
//   alu_sub    out  1   ALU subtract (also used for the set-less-than compare)
//   alu_sign   out  1   signed compare for SLT/SLTI
//   rd_out     out  5   destination register index
//   out_pc     out  32  pc of the held instruction
//   illegal    out  1   held instruction is not OP/OP-IMM/LUI/AUIPC
// ---------------------------------------------------------------------------
module alu_dispatch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_crl,
  output logic        alu_sub,
  output logic        alu_sign,
  output logic [4:0]  rd_out,
  output logic [31:0] out_pc,
  output logic        illegal
);

  // Major opcodes handled by this stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct3 codes
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 codes that are legal in front of OP and shift-immediate encodings
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation select encoding
  localparam logic [3:0] CRL_ADD = 4'b0000;
  localparam logic [3:0] CRL_XOR = 4'b0001;
  localparam logic [3:0] CRL_OR  = 4'b0010;
  localparam logic [3:0] CRL_AND = 4'b0011;
  localparam logic [3:0] CRL_SLL = 4'b0100;
  localparam logic [3:0] CRL_SRL = 4'b0101;
  localparam logic [3:0] CRL_SRA = 4'b0110;
  localparam logic [3:0] CRL_SLT = 4'b1000;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        alt_bit;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign alt_bit = inst[30];
  assign imm_i   = {{20{inst[31]}}, inst[31:20]};
  assign imm_u   = {inst[31:12], 12'b0};
  assign shamt   = {27'b0, inst[24:20]};

  // rs1 index is resolved upstream by the register-file read; not needed here.
  logic unused_rs1_field;
  assign unused_rs1_field = ^inst[19:15];

  // Combinational decode results, captured into the output registers on
  // transfer-in.
  logic        dec_illegal;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_crl;
  logic        dec_sub;
  logic        dec_sign;

  // Operation select from funct3 alone. inst[30] only matters for the right
  // shift; for funct3 000 add vs. subtract is carried by alu_sub instead.
  logic [3:0] funct3_crl;

  always_comb begin
    funct3_crl = CRL_ADD;
    case (funct3)
      F3_ADD:  funct3_crl = CRL_ADD;
      F3_SLL:  funct3_crl = CRL_SLL;
      F3_SLT:  funct3_crl = CRL_SLT;
      F3_SLTU: funct3_crl = CRL_SLT;
      F3_XOR:  funct3_crl = CRL_XOR;
      F3_SR:   funct3_crl = alt_bit ? CRL_SRA : CRL_SRL;
      F3_OR:   funct3_crl = CRL_OR;
      F3_AND:  funct3_crl = CRL_AND;
      default: funct3_crl = CRL_ADD;
    endcase
  end

  // Both set-less-than flavours subtract to compare; only SLT/SLTI is signed.
  logic is_compare;
  logic is_signed_compare;

  assign is_compare        = (funct3 == F3_SLT) || (funct3 == F3_SLTU);
  assign is_signed_compare = (funct3 == F3_SLT);

  // Legality of the funct7 field for register-register operations: the
  // alternate encoding only exists for SUB and SRA.
  logic op_legal;

  always_comb begin
    op_legal = 1'b0;
    if (funct7 == F7_BASE) begin
      op_legal = 1'b1;
    end else if (funct7 == F7_ALT) begin
      op_legal = (funct3 == F3_ADD) || (funct3 == F3_SR);
    end
  end

  // Legality for OP-IMM: only the shift-immediates constrain the upper bits,
  // everything else uses them as part of the immediate.
  logic op_imm_legal;
  logic op_imm_shift;

  assign op_imm_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  always_comb begin
    op_imm_legal = 1'b1;
    if (funct3 == F3_SLL) begin
      op_imm_legal = (funct7 == F7_BASE);
    end else if (funct3 == F3_SR) begin
      op_imm_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
    end
  end

  // Main decode. Defaults are the all-zero "illegal" payload, so any path
  // that flags illegal simply leaves the operands and controls at zero.
  always_comb begin
    dec_illegal = 1'b0;
    dec_a       = 32'h0;
    dec_b       = 32'h0;
    dec_crl     = CRL_ADD;
    dec_sub     = 1'b0;
    dec_sign    = 1'b0;

    case (opcode)
      OPC_OP: begin
        if (op_legal) begin
          dec_a    = rs1_data;
          dec_b    = rs2_data;
          dec_crl  = funct3_crl;
          dec_sub  = is_compare || ((funct3 == F3_ADD) && alt_bit);
          dec_sign = is_signed_compare;
        end else begin
          dec_illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        if (op_imm_legal) begin
          dec_a    = rs1_data;
          dec_b    = op_imm_shift ? shamt : imm_i;
          dec_crl  = funct3_crl;
          // ADDI never subtracts even when imm bit 30 happens to be set.
          dec_sub  = is_compare;
          dec_sign = is_signed_compare;
        end else begin
          dec_illegal = 1'b1;
        end
      end

      OPC_LUI: begin
        dec_a = 32'h0;
        dec_b = imm_u;
      end

      OPC_AUIPC: begin
        dec_a = pc;
        dec_b = imm_u;
      end

      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Handshake. flush must win over a downstream drain so that a redirected
  // instruction never slips in behind the one being discarded.
  logic take;

  assign in_ready = (~out_valid | out_ready) & ~flush;
  assign take     = in_valid & in_ready;

  // Valid bit: a same-edge drain and load keeps valid high (no bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload registers only change on transfer-in, so they hold through both
  // stalls and drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal  <= 1'b0;
      alu_a    <= 32'h0;
      alu_b    <= 32'h0;
      alu_crl  <= CRL_ADD;
      alu_sub  <= 1'b0;
      alu_sign <= 1'b0;
      rd_out   <= 5'h0;
      out_pc   <= 32'h0;
    end else if (take) begin
      illegal  <= dec_illegal;
      alu_a    <= dec_a;
      alu_b    <= dec_b;
      alu_crl  <= dec_crl;
      alu_sub  <= dec_sub;
      alu_sign <= dec_sign;
      rd_out   <= inst[11:7];
      out_pc   <= pc;
    end
  end

endmodule
